// File: rtl/e_mdu_pkg.sv
// Shared pipeline definitions for the execute-stage multiply/divide unit:
// md_op encodings and default operation latencies.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    function automatic logic is_md_start_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO; the result is computed at
// issue and committed when the busy countdown expires.
//
// state  | meaning
// S_IDLE | no operation in flight; accepts start and MTHI/MTLO
// S_RUN  | counting down the busy period; commits tmp result on count 1
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic [31:0] E_GRF_rs,
    input  logic [31:0] E_GRF_rt,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_rdata
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               wr_q;
    logic [31:0]        hi_q, lo_q, tmp_hi_q, tmp_lo_q;

    logic [31:0]        res_hi_d, res_lo_d;
    logic               res_wr_d, is_div_d;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;

    always_comb begin
        prod_s   = $signed({{32{E_GRF_rs[31]}}, E_GRF_rs}) * $signed({{32{E_GRF_rt[31]}}, E_GRF_rt});
        prod_u   = {32'd0, E_GRF_rs} * {32'd0, E_GRF_rt};
        is_div_d = (md_op == MD_DIV) || (md_op == MD_DIVU);
        // Divide by zero still runs the full busy period but never commits.
        res_wr_d = !(is_div_d && (E_GRF_rt == 32'd0));
        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
        case (md_op)
            MD_MULT: begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi_d = prod_u[63:32];
                res_lo_d = prod_u[31:0];
            end
            MD_DIV: begin
                // Most-negative / -1 overflows a 32-bit quotient; pin the architectural result.
                if (E_GRF_rs == 32'h8000_0000 && E_GRF_rt == 32'hFFFF_FFFF) begin
                    res_lo_d = 32'h8000_0000;
                    res_hi_d = 32'd0;
                end else if (E_GRF_rt != 32'd0) begin
                    res_lo_d = $signed(E_GRF_rs) / $signed(E_GRF_rt);
                    res_hi_d = $signed(E_GRF_rs) % $signed(E_GRF_rt);
                end
            end
            MD_DIVU: begin
                if (E_GRF_rt != 32'd0) begin
                    res_lo_d = E_GRF_rs / E_GRF_rt;
                    res_hi_d = E_GRF_rs % E_GRF_rt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            wr_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
        end else if (state_q == S_IDLE) begin
            if (start && is_md_start_op(md_op)) begin
                tmp_hi_q <= res_hi_d;
                tmp_lo_q <= res_lo_d;
                wr_q     <= res_wr_d;
                cnt_q    <= is_div_d ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                busy_q   <= 1'b1;
                state_q  <= S_RUN;
            end else if (md_op == MD_MTHI) begin
                hi_q <= E_GRF_rs;
            end else if (md_op == MD_MTLO) begin
                lo_q <= E_GRF_rs;
            end
        end else begin
            if (cnt_q == CNT_W'(1)) begin
                if (wr_q) begin
                    hi_q <= tmp_hi_q;
                    lo_q <= tmp_lo_q;
                end
                cnt_q   <= '0;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        md_rdata = 32'd0;
        if (md_op == MD_MFHI)      md_rdata = hi_q;
        else if (md_op == MD_MFLO) md_rdata = lo_q;
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
